// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one ALU between N_REQ requesters.
//            A request is accepted in IDLE, issued to the ALU in ISSUE, and
//            its result is routed back to the owner from WAIT as a one-cycle
//            response pulse. NOP requests are answered directly from IDLE
//            without touching the ALU.
// Ports    : i_clk, i_rst_n        clock / async active-low reset
//            i_req_valid/o_req_ready  per-requester handshake (one-hot grant)
//            i_req_a/i_req_b/i_req_op packed operands/opcode (32/32/2 bits each)
//            o_rsp_valid/o_rsp_result/o_rsp_err  response to the owner
//            o_busy                high while ISSUE or WAIT
//            o_alu_a/o_alu_b/o_alu_op/i_alu_ready  ALU issue interface
//            i_alu_res_valid/i_alu_result          ALU result return
// Options  : ALU_ARB_TIMEOUT_EN  enables the WAIT watchdog (TIMEOUT cycles)
//            and the error response; otherwise o_rsp_err is tied low.
// Revision : 1.0  initial release
// ============================================================================

`ifndef OP_NOP
`define OP_NOP 2'b00
`endif
`ifndef OP_ADD
`define OP_ADD 2'b01
`endif
`ifndef OP_SUB
`define OP_SUB 2'b10
`endif
`ifndef OP_AND
`define OP_AND 2'b11
`endif

module alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic [32*N_REQ-1:0]  i_req_a,
    input  logic [32*N_REQ-1:0]  i_req_b,
    input  logic [2*N_REQ-1:0]   i_req_op,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [31:0]          o_rsp_result,
    output logic                 o_rsp_err,
    output logic                 o_busy,
    output logic [31:0]          o_alu_a,
    output logic [31:0]          o_alu_b,
    output logic [1:0]           o_alu_op,
    input  logic                 i_alu_ready,
    input  logic                 i_alu_res_valid,
    input  logic [31:0]          i_alu_result
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("alu_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_result_q, rsp_result_d;

    logic                 gnt_found;
    logic [PTR_W-1:0]     gnt_idx;
    logic [N_REQ-1:0]     gnt_onehot;
    logic [N_REQ-1:0]     owner_onehot;
    logic [1:0]           gnt_op;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rsp_err_q, rsp_err_d;
`endif

    // Rotating-priority scan: first valid requester at or after the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && i_req_valid[(int'(ptr_q) + i) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    assign gnt_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
    assign owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign gnt_op       = i_req_op[2*int'(gnt_idx) +: 2];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = '0;
        rsp_result_d = '0;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    a_d     = i_req_a[32*int'(gnt_idx) +: 32];
                    b_d     = i_req_b[32*int'(gnt_idx) +: 32];
                    op_d    = gnt_op;
                    owner_d = gnt_idx;
                    ptr_d   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    // A NOP never reaches the ALU; answer it straight from IDLE.
                    if (gnt_op == `OP_NOP) begin
                        rsp_valid_d = gnt_onehot;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (i_alu_ready) begin
                    state_d = S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // A result in the same cycle the limit is reached takes priority.
                if (i_alu_res_valid) begin
                    rsp_valid_d  = owner_onehot;
                    rsp_result_d = i_alu_result;
                    state_d      = S_IDLE;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = owner_onehot;
                    rsp_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= `OP_NOP;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    // The grant is combinational and qualified by reset so no acceptance is
    // advertised while the block is held in reset.
    assign o_req_ready  = (state_q == S_IDLE && gnt_found && i_rst_n) ? gnt_onehot : '0;
    assign o_alu_op     = (state_q == S_ISSUE) ? op_q : `OP_NOP;
    assign o_alu_a      = (state_q == S_ISSUE) ? a_q  : 32'd0;
    assign o_alu_b      = (state_q == S_ISSUE) ? b_q  : 32'd0;
    assign o_busy       = (state_q != S_IDLE);
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = rsp_result_q;

endmodule

`default_nettype wire
